alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Sequences the alarm tune player: decides when it sounds, which song it plays,
//  and when it restarts. Handles ring timeout, snooze countdown, snooze limit and
//  song escalation. Sits between the time-compare logic / user buttons and the
//  music player. Its alarm, sel and song_restart outputs drive the player's
//  alarm, sel and reset inputs.
// PARAMETERS
//  RING_SECS    60   seconds a ring lasts before auto-timeout (>=1)
//  SNOOZE_SECS  540  snooze length in seconds (>=1)
//  MAX_SNOOZES  3    snoozes allowed per alarm event (0..7)
//  ESCALATE     1    1: sel advances by 1 (wraps 3->0) on each re-ring after snooze
//  CNT_W        10   second-counter width; must hold max(RING_SECS,SNOOZE_SECS)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      async active-high reset
//  tick_1hz     in   1      one-cycle enable pulse, once per second
//  arm_en       in   1      alarm armed (level); low forces IDLE
//  alarm_match  in   1      level, high while current time == alarm time
//  snooze_btn   in   1      debounced level
//  stop_btn     in   1      debounced level
//  song_cfg     in   2      user-selected song, latched at trigger
//  alarm        out  1      1 = player audible
//  sel          out  2      song select to player
//  song_restart out  1      one-cycle pulse; restarts player at song start
//  missed       out  1      sticky: a ring timed out unanswered
//  state        out  2      0 IDLE, 1 RING, 2 SNOOZE
//  secs_left    out  CNT_W  remaining seconds in current RING/SNOOZE, 0 in IDLE
// BEHAVIOUR
//  - All outputs registered. Reset values: alarm=0, sel=0, song_restart=0,
//    missed=0, state=IDLE, secs_left=0, snooze count=0.
//  - Edges: alarm_match, snooze_btn and stop_btn each pass through a rising-edge
//    detector (evt = in & ~in_q). in_q resets to 1, so an input held high
//    through reset release raises no event. Outputs change at the first clk
//    edge that samples the input high.
//  - Event priority, highest first: arm_en=0 > stop > snooze > tick/timeout >
//    match.
//  - IDLE: alarm=0. On match evt with arm_en=1 -> RING: sel<=song_cfg,
//    secs_left<=RING_SECS, snooze count<=0, song_restart pulses.
//  - RING: alarm=1.
//    - stop evt -> IDLE; missed<=0.
//    - snooze evt with count<MAX_SNOOZES -> SNOOZE: secs_left<=SNOOZE_SECS,
//      count++. At count==MAX_SNOOZES, snooze evt is ignored.
//    - tick: secs_left--. A tick with secs_left==1 -> IDLE, missed<=1.
//  - SNOOZE: alarm=0. stop evt -> IDLE. tick: secs_left--.
//    - A tick with secs_left==1 -> RING: secs_left<=RING_SECS, song_restart
//      pulses, and sel<=sel+1 (2-bit wrap) when ESCALATE=1.
//  - In RING/SNOOZE, match evt is ignored (no retrigger, no counter reload).
//  - arm_en low in any state -> IDLE next cycle, alarm=0. missed is unchanged.
//  - In the same cycle as a snooze/stop evt, tick does not decrement the
//    counter; the event's load wins.
//  - Entering IDLE sets secs_left<=0. In IDLE, sel holds its last value.
//  - song_restart is high for exactly one cycle per RING entry and never
//    otherwise. Integrator ORs it with rst into the player reset.
//  - rst mid-ring: immediate return to reset values (alarm=0 asynchronously).
// TESTING (RING_SECS=3, SNOOZE_SECS=2, MAX_SNOOZES=1, ESCALATE=1 unless noted)
//  1 arm_en=1, song_cfg=2, match rises -> next edge: state=1, alarm=1, sel=2,
//    secs_left=3, song_restart high 1 cycle.
//  2 In RING: 3 ticks, no buttons -> state=0, alarm=0, missed=1. Then stop evt
//    -> missed=0.
//  3 RING, snooze -> SNOOZE, secs_left=2; 2 ticks -> RING, sel=3, one
//    song_restart pulse. Second snooze ignored (state stays 1). Repeat with
//    sel=3 -> re-ring sel=0 (wrap).
//  4 Simultaneous: snooze evt with tick in RING -> SNOOZE, secs_left=2.
//    Stop + snooze same cycle -> IDLE.
//  5 match held high during rst release -> stays IDLE. match rising while in
//    SNOOZE -> no state or secs_left change.
//  6 arm_en drops in SNOOZE -> IDLE. rst asserted mid-RING -> alarm=0 at once,
//    all outputs at reset values.

Source files
------------

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm tune sequencer: ring timeout, snooze, snooze limit, song escalation
module alarm_sequencer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZES = 3,
    parameter int ESCALATE    = 1,
    parameter int CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             arm_en,
    input  logic             alarm_match,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    input  logic [1:0]       song_cfg,
    output logic             alarm,
    output logic [1:0]       sel,
    output logic             song_restart,
    output logic             missed,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] secs_left
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       MAX_SNZ     = 3'(MAX_SNOOZES);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_d;
    logic [2:0]       snz_q, snz_d;
    logic             restart_d, missed_d;
    logic             match_q, snooze_q, stop_q;
    logic             match_evt, snooze_evt, stop_evt;

    // Previous-level registers reset high so a level held through reset is not an event.
    assign match_evt  = alarm_match & ~match_q;
    assign snooze_evt = snooze_btn  & ~snooze_q;
    assign stop_evt   = stop_btn    & ~stop_q;

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        sel_d     = sel;
        snz_d     = snz_q;
        missed_d  = missed;
        restart_d = 1'b0;
        if (!arm_en) begin
            st_d  = IDLE;
            cnt_d = '0;
        end else if (stop_evt) begin
            st_d     = IDLE;
            cnt_d    = '0;
            missed_d = 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (match_evt) begin
                        st_d      = RING;
                        cnt_d     = RING_LOAD;
                        sel_d     = song_cfg;
                        snz_d     = '0;
                        restart_d = 1'b1;
                    end
                end
                RING: begin
                    if (snooze_evt && (snz_q < MAX_SNZ)) begin
                        st_d  = SNOOZE;
                        cnt_d = SNOOZE_LOAD;
                        snz_d = snz_q + 3'd1;
                    end else if (tick_1hz) begin
                        if (cnt_q == CNT_ONE) begin
                            st_d     = IDLE;
                            cnt_d    = '0;
                            missed_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                SNOOZE: begin
                    if (tick_1hz) begin
                        if (cnt_q == CNT_ONE) begin
                            st_d      = RING;
                            cnt_d     = RING_LOAD;
                            restart_d = 1'b1;
                            if (ESCALATE != 0) sel_d = sel + 2'd1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= IDLE;
            cnt_q        <= '0;
            sel          <= 2'd0;
            snz_q        <= 3'd0;
            missed       <= 1'b0;
            song_restart <= 1'b0;
            alarm        <= 1'b0;
            match_q      <= 1'b1;
            snooze_q     <= 1'b1;
            stop_q       <= 1'b1;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            sel          <= sel_d;
            snz_q        <= snz_d;
            missed       <= missed_d;
            song_restart <= restart_d;
            alarm        <= (st_d == RING);
            match_q      <= alarm_match;
            snooze_q     <= snooze_btn;
            stop_q       <= stop_btn;
        end
    end

    assign state     = st_q;
    assign secs_left = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - scoreboard bench for alarm_sequencer
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, arm_en, alarm_match, snooze_btn, stop_btn;
    logic [1:0] song_cfg;
    logic       alarm, song_restart, missed;
    logic [1:0] sel, state;
    logic [9:0] secs_left;

    typedef struct packed {
        logic [1:0] st;
        logic       al;
        logic [1:0] sel;
        logic       rs;
        logic       ms;
        logic [9:0] sl;
    } obs_t;

    typedef struct packed {
        logic       arm;
        logic       mt;
        logic       sn;
        logic       sp;
        logic       tk;
        logic [1:0] cfg;
    } stim_t;

    obs_t  obs;
    obs_t  exp_v;
    stim_t cur;
    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    checks = 0;
    int    fails  = 0;

    assign obs = {state, alarm, sel, song_restart, missed, secs_left};

    alarm_sequencer #(
        .RING_SECS(3), .SNOOZE_SECS(2), .MAX_SNOOZES(1), .ESCALATE(1), .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .arm_en(arm_en),
        .alarm_match(alarm_match), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .song_cfg(song_cfg), .alarm(alarm), .sel(sel), .song_restart(song_restart),
        .missed(missed), .state(state), .secs_left(secs_left)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int st, al, sl_sel, rs, ms, sl);
        return {2'(st), 1'(al), 2'(sl_sel), 1'(rs), 1'(ms), 10'(sl)};
    endfunction

    task automatic add(input int arm, mt, sn, sp, tk, cfg, st, al, s_sel, rs, ms, sl);
        stim_q.push_back({1'(arm), 1'(mt), 1'(sn), 1'(sp), 1'(tk), 2'(cfg)});
        exp_q.push_back(mk(st, al, s_sel, rs, ms, sl));
    endtask

    task automatic apply(input stim_t s);
        arm_en      = s.arm;
        alarm_match = s.mt;
        snooze_btn  = s.sn;
        stop_btn    = s.sp;
        tick_1hz    = s.tk;
        song_cfg    = s.cfg;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        apply({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2});
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_state got %h required %h", obs, exp_v);
        end
        rst = 1'b0;
        // match still high across release, then low
        add(1, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0);
        for (int i = 0; stim_q.size() != 0; i++) begin
            cur = stim_q.pop_front();
            apply(cur);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL reset_release[%0d] got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_trigger_timeout;
        add(1, 1, 0, 0, 0, 2,  1, 1, 2, 1, 0, 3);
        add(1, 0, 0, 0, 0, 2,  1, 1, 2, 0, 0, 3);
        add(1, 0, 0, 0, 1, 2,  1, 1, 2, 0, 0, 2);
        add(1, 0, 0, 0, 1, 2,  1, 1, 2, 0, 0, 1);
        add(1, 0, 0, 0, 1, 2,  0, 0, 2, 0, 1, 0);
        add(1, 0, 0, 1, 0, 2,  0, 0, 2, 0, 0, 0);
        add(1, 0, 0, 0, 0, 2,  0, 0, 2, 0, 0, 0);
        for (int i = 0; stim_q.size() != 0; i++) begin
            cur = stim_q.pop_front();
            apply(cur);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL trigger_timeout[%0d] got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_snooze_escalate;
        add(1, 1, 0, 0, 0, 2,  1, 1, 2, 1, 0, 3);
        add(1, 0, 1, 0, 0, 2,  2, 0, 2, 0, 0, 2);
        add(1, 0, 0, 0, 0, 2,  2, 0, 2, 0, 0, 2);
        add(1, 0, 0, 0, 1, 2,  2, 0, 2, 0, 0, 1);
        add(1, 0, 0, 0, 1, 2,  1, 1, 3, 1, 0, 3);
        add(1, 0, 0, 0, 0, 2,  1, 1, 3, 0, 0, 3);
        add(1, 0, 1, 0, 0, 2,  1, 1, 3, 0, 0, 3);
        add(1, 0, 0, 0, 1, 2,  1, 1, 3, 0, 0, 2);
        add(1, 0, 0, 1, 0, 2,  0, 0, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 2,  0, 0, 3, 0, 0, 0);
        add(1, 1, 0, 0, 0, 3,  1, 1, 3, 1, 0, 3);
        add(1, 0, 1, 0, 0, 3,  2, 0, 3, 0, 0, 2);
        add(1, 0, 0, 0, 1, 3,  2, 0, 3, 0, 0, 1);
        add(1, 0, 0, 0, 1, 3,  1, 1, 0, 1, 0, 3);
        add(1, 0, 0, 1, 0, 3,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0);
        for (int i = 0; stim_q.size() != 0; i++) begin
            cur = stim_q.pop_front();
            apply(cur);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL snooze_escalate[%0d] got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous;
        add(1, 1, 0, 0, 0, 1,  1, 1, 1, 1, 0, 3);
        add(1, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 2);
        add(1, 0, 1, 0, 1, 1,  2, 0, 1, 0, 0, 2);
        add(1, 0, 0, 0, 1, 1,  2, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1,  1, 1, 2, 1, 0, 3);
        add(1, 0, 1, 1, 0, 1,  0, 0, 2, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1,  0, 0, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 3);
        add(1, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        for (int i = 0; stim_q.size() != 0; i++) begin
            cur = stim_q.pop_front();
            apply(cur);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL simultaneous[%0d] got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_match_ignore_disarm;
        add(1, 1, 0, 0, 0, 2,  1, 1, 2, 1, 0, 3);
        add(1, 0, 1, 0, 0, 2,  2, 0, 2, 0, 0, 2);
        add(1, 1, 0, 0, 0, 2,  2, 0, 2, 0, 0, 2);
        add(1, 0, 0, 0, 1, 2,  2, 0, 2, 0, 0, 1);
        add(0, 0, 0, 0, 0, 2,  0, 0, 2, 0, 0, 0);
        add(0, 1, 0, 0, 0, 2,  0, 0, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 2,  0, 0, 2, 0, 0, 0);
        add(1, 0, 0, 0, 0, 2,  0, 0, 2, 0, 0, 0);
        for (int i = 0; stim_q.size() != 0; i++) begin
            cur = stim_q.pop_front();
            apply(cur);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL match_ignore_disarm[%0d] got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_ring;
        add(1, 1, 0, 0, 0, 1,  1, 1, 1, 1, 0, 3);
        add(1, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 2);
        add(1, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1,  0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 0);
        add(1, 1, 0, 0, 0, 3,  1, 1, 3, 1, 1, 3);
        add(1, 0, 0, 0, 0, 3,  1, 1, 3, 0, 1, 3);
        for (int i = 0; stim_q.size() != 0; i++) begin
            cur = stim_q.pop_front();
            apply(cur);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL ring_missed[%0d] got %h required %h", i, obs, exp_v);
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL async_reset got %h required %h", obs, exp_v);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_trigger_timeout();
        test_snooze_escalate();
        test_simultaneous();
        test_match_ignore_disarm();
        test_reset_mid_ring();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
